logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_arbiter_pkg.sv | 10 +
 rtl/logic_unit_arbiter_logic_unit.sv | 22 ++
 rtl/logic_unit_arbiter.sv | 90 +++++++++
 tb/tb_logic_unit_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the two-port logic-unit arbiter: opcode encodings and source IDs.
package logic_unit_arbiter_pkg;
  localparam logic [1:0] LU_AND = 2'b00;
  localparam logic [1:0] LU_OR  = 2'b01;
  localparam logic [1:0] LU_XOR = 2'b10;
  localparam logic [1:0] LU_NOR = 2'b11;

  localparam logic SRC_EX = 1'b0;
  localparam logic SRC_BR = 1'b1;
endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Purely combinational bitwise logic unit: y = op(a, b).
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  always_comb begin
    o_y = '0;
    case (i_op)
      LU_AND:  o_y = i_a & i_b;
      LU_OR:   o_y = i_a | i_b;
      LU_XOR:  o_y = i_a ^ i_b;
      LU_NOR:  o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between the EX path (port 0) and the
// branch/immediate-mask path (port 1), with a single registered, back-pressurable result.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_src;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_last_grant;

  logic             w_slot_free;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [TAG_W-1:0] w_tag;
  logic [WIDTH-1:0] w_y;

  // Grants depend only on the valids and last_grant, so neither ready feeds the other.
  assign w_slot_free = !r_res_valid || res_ready;
  assign w_grant0    = r0_valid && (!r1_valid || (r_last_grant == SRC_BR));
  assign w_grant1    = r1_valid && (!r0_valid || (r_last_grant == SRC_EX));
  assign r0_ready    = w_grant0 && w_slot_free && !reset;
  assign r1_ready    = w_grant1 && w_slot_free && !reset;
  assign w_accept    = r0_ready || r1_ready;

  assign w_op  = w_grant1 ? r1_op  : r0_op;
  assign w_a   = w_grant1 ? r1_a   : r0_a;
  assign w_b   = w_grant1 ? r1_b   : r0_b;
  assign w_tag = w_grant1 ? r1_tag : r0_tag;

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .i_op (w_op),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_y  (w_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_src    <= SRC_EX;
      r_res_tag    <= '0;
      r_last_grant <= SRC_BR;
    end else if (w_accept) begin
      r_res_valid  <= 1'b1;
      r_res_data   <= w_y;
      r_res_src    <= w_grant1 ? SRC_BR : SRC_EX;
      r_res_tag    <= w_tag;
      r_last_grant <= w_grant1 ? SRC_BR : SRC_EX;
    end else if (res_ready) begin
      // Drain with no replacement: data/src/tag keep their last values.
      r_res_valid  <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_src   = r_res_src;
  assign res_tag   = r_res_tag;
  assign busy      = r_res_valid || r0_valid || r1_valid;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter.
module tb_logic_unit_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [1:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_tag, r1_tag;
  logic        res_valid, res_ready, res_src, busy;
  logic [31:0] res_data;
  logic [3:0]  res_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag), .busy(busy)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_ready = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op = '0; r0_a = '0; r0_b = '0; r0_tag = '0;
    r1_op = '0; r1_a = '0; r1_b = '0; r1_tag = '0;
    step(); step();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", res_valid); end
    tests++; if (res_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", res_data); end
    tests++; if (res_src !== 1'b0 || res_tag !== 4'h0) begin fails++; $display("FAIL reset_src_tag got %0b/%0d exp 0/0", res_src, res_tag); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    r0_valid = 1'b1; #1;
    tests++; if (r0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b exp 0", r0_ready); end
    r0_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    r0_valid = 1'b1; r0_op = 2'b01; r0_a = 32'hF0F0_0000; r0_b = 32'h0000_0F0F; r0_tag = 4'd3;
    #1;
    tests++; if (r0_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %0b exp 1", r0_ready); end
    step();
    r0_valid = 1'b0;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", res_valid); end
    tests++; if (res_data !== 32'hF0F0_0F0F) begin fails++; $display("FAIL single_data got %h exp f0f00f0f", res_data); end
    tests++; if (res_src !== 1'b0 || res_tag !== 4'd3) begin fails++; $display("FAIL single_src_tag got %0b/%0d exp 0/3", res_src, res_tag); end
  endtask

  task automatic test_opcodes();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h0FF0_0000; exp_tab[1] = 32'hFFFF_0FF0;
    exp_tab[2] = 32'hF00F_0FF0; exp_tab[3] = 32'h0000_F00F;
    for (int i = 0; i < 4; i++) begin
      r1_valid = 1'b1; r1_op = 2'(i); r1_a = 32'hFFFF_0000; r1_b = 32'h0FF0_0FF0; r1_tag = 4'(i + 8);
      step();
      tests++;
      if (res_valid !== 1'b1 || res_data !== exp_tab[i] || res_src !== 1'b1 || res_tag !== 4'(i + 8)) begin
        fails++;
        $display("FAIL opcode_%0d got v=%0b d=%h s=%0b t=%0d exp v=1 d=%h s=1 t=%0d",
                 i, res_valid, res_data, res_src, res_tag, exp_tab[i], i + 8);
      end
    end
    r1_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] exp_d;
    for (int i = 0; i < 6; i++) begin
      r0_valid = 1'b1; r0_op = 2'b00; r0_a = 32'hFFFF_FFFF; r0_b = 32'hAAAA_0000 | 32'(i); r0_tag = 4'(i);
      r1_valid = 1'b1; r1_op = 2'b00; r1_a = 32'hFFFF_FFFF; r1_b = 32'h5555_0000 | 32'(i); r1_tag = 4'(i + 8);
      #1;
      tests++;
      if (r0_ready !== ((i % 2) == 0) || r1_ready !== ((i % 2) == 1)) begin
        fails++; $display("FAIL contention_ready_%0d got %0b%0b exp %0b%0b", i, r1_ready, r0_ready, (i % 2) == 1, (i % 2) == 0);
      end
      step();
      exp_d = ((i % 2) == 0) ? (32'hAAAA_0000 | 32'(i)) : (32'h5555_0000 | 32'(i));
      tests++;
      if (res_valid !== 1'b1 || res_src !== 1'(i % 2) || res_data !== exp_d || res_tag !== 4'(i + 8 * (i % 2))) begin
        fails++;
        $display("FAIL contention_res_%0d got v=%0b s=%0b d=%h t=%0d exp v=1 s=%0d d=%h t=%0d",
                 i, res_valid, res_src, res_data, res_tag, i % 2, exp_d, i + 8 * (i % 2));
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    // Pending result is the last contention accept: port 1, tag 13, data 5555_0005.
    res_ready = 1'b0;
    r1_valid = 1'b1; r1_op = 2'b01; r1_a = 32'h1234_0000; r1_b = 32'h0000_5678; r1_tag = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (r1_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d got %0b exp 0", i, r1_ready); end
      step();
      tests++;
      if (res_valid !== 1'b1 || res_data !== 32'h5555_0005 || res_src !== 1'b1 || res_tag !== 4'd13) begin
        fails++;
        $display("FAIL bp_hold_%0d got v=%0b d=%h s=%0b t=%0d exp v=1 d=55550005 s=1 t=13",
                 i, res_valid, res_data, res_src, res_tag);
      end
    end
    res_ready = 1'b1; #1;
    tests++; if (r1_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b exp 1", r1_ready); end
    step();
    r1_valid = 1'b0;
    tests++;
    if (res_valid !== 1'b1 || res_data !== 32'h1234_5678 || res_src !== 1'b1 || res_tag !== 4'd7) begin
      fails++;
      $display("FAIL bp_new_res got v=%0b d=%h s=%0b t=%0d exp v=1 d=12345678 s=1 t=7",
               res_valid, res_data, res_src, res_tag);
    end
  endtask

  task automatic test_drain();
    step();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %0b exp 0", res_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy got %0b exp 0", busy); end
    tests++; if (res_data !== 32'h1234_5678) begin fails++; $display("FAIL drain_data_hold got %h exp 12345678", res_data); end
  endtask

  task automatic test_reset_mid();
    r0_valid = 1'b1; r0_op = 2'b10; r0_a = 32'hFFFF_FFFF; r0_b = 32'h0000_FFFF; r0_tag = 4'd5;
    step();
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL mid_setup_valid got %0b exp 1", res_valid); end
    r1_valid = 1'b1; r1_op = 2'b00; r1_a = 32'hFFFF_FFFF; r1_b = 32'h0000_00FF; r1_tag = 4'd9;
    res_ready = 1'b0; reset = 1'b1; #1;
    tests++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ready got %0b%0b exp 00", r1_ready, r0_ready); end
    step();
    tests++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_src !== 1'b0 || res_tag !== 4'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs got v=%0b d=%h s=%0b t=%0d exp all 0", res_valid, res_data, res_src, res_tag);
    end
    reset = 1'b0; res_ready = 1'b1; #1;
    tests++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin fails++; $display("FAIL mid_first_grant got %0b%0b exp 01", r1_ready, r0_ready); end
    step();
    tests++;
    if (res_valid !== 1'b1 || res_src !== 1'b0 || res_data !== 32'hFFFF_0000 || res_tag !== 4'd5) begin
      fails++;
      $display("FAIL mid_first_res got v=%0b s=%0b d=%h t=%0d exp v=1 s=0 d=ffff0000 t=5", res_valid, res_src, res_data, res_tag);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_contention();
    test_back_pressure();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
